// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/bubble/flush/freeze control for IF/ID and ID/EX.
// Ports: IF/ID operand fields, ID/EX dest info, branch and data-memory
// handshake in; PC/IF-ID write enables, bubble, flush, freeze, sticky
// memory-timeout flag and saturating stall/flush counters out.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS1Addr_i,
  input  logic [4:0]       IFID_RS2Addr_i,
  input  logic             IFID_RS2Used_i,
  input  logic             IsBranch_i,
  input  logic             BranchTaken_i,
  input  logic             IDEX_MemRead_i,
  input  logic             IDEX_RegWrite_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             MemReq_i,
  input  logic             MemAck_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             Freeze_o,
  output logic             MemErr_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam int WC_W = 16;
  localparam logic [WC_W-1:0] TIMEOUT = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_STALL2 = 2'd1,
    MEM_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [WC_W-1:0]   waitcnt_q, waitcnt_d;
  logic              memerr_q, memerr_d;
  logic [CNT_W-1:0]  stallcnt_q, stallcnt_d;
  logic [CNT_W-1:0]  flushcnt_q, flushcnt_d;

  logic match;
  logic memwait;
  logic lu;
  logic alu_br;
  logic rd_nz;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired zero, so it can never carry a dependency.
  always_comb begin
    rd_nz   = (IDEX_RDaddr_i != 5'd0);
    rs1_hit = (IDEX_RDaddr_i == IFID_RS1Addr_i);
    rs2_hit = IFID_RS2Used_i
              && (IDEX_RDaddr_i == IFID_RS2Addr_i);
    match   = rd_nz && (rs1_hit || rs2_hit);
    memwait = MemReq_i && !MemAck_i;
    lu      = IDEX_MemRead_i && match;
    alu_br  = IsBranch_i && IDEX_RegWrite_i
              && !IDEX_MemRead_i && match;
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    waitcnt_d   = waitcnt_q;
    memerr_d    = memerr_q;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    NoOp_o      = 1'b0;
    Flush_o     = 1'b0;
    Freeze_o    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (memwait) begin
          Freeze_o    = 1'b1;
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          state_d     = MEM_WAIT;
          ret_d       = RUN;
          waitcnt_d   = WC_W'(1);
        end else if (lu) begin
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          NoOp_o      = 1'b1;
          // load value reaches a branch comparator in ID only
          // after a second bubble
          if (IsBranch_i) begin
            state_d = BR_STALL2;
          end
        end else if (alu_br) begin
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          NoOp_o      = 1'b1;
        end else if (IsBranch_i && BranchTaken_i) begin
          Flush_o = 1'b1;
        end
      end

      BR_STALL2: begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        if (memwait) begin
          // freeze holds ID/EX, so the bubble must not be injected;
          // the second stall resumes after the memory wait
          Freeze_o  = 1'b1;
          state_d   = MEM_WAIT;
          ret_d     = BR_STALL2;
          waitcnt_d = WC_W'(1);
        end else begin
          NoOp_o  = 1'b1;
          state_d = RUN;
        end
      end

      MEM_WAIT: begin
        Freeze_o    = 1'b1;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        if (MemAck_i || !MemReq_i) begin
          state_d   = ret_q;
          waitcnt_d = '0;
        end else if (waitcnt_q == TIMEOUT) begin
          memerr_d  = 1'b1;
          state_d   = ret_q;
          waitcnt_d = '0;
        end else begin
          waitcnt_d = waitcnt_q + WC_W'(1);
        end
      end

      default: begin
        state_d = RUN;
        ret_d   = RUN;
      end
    endcase

    if (rst_i) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
      Flush_o     = 1'b0;
      Freeze_o    = 1'b0;
    end
  end

  // statistics saturate at all-ones instead of wrapping
  always_comb begin
    stallcnt_d = stallcnt_q;
    flushcnt_d = flushcnt_q;
    if (!PCWrite_o && (stallcnt_q != '1)) begin
      stallcnt_d = stallcnt_q + CNT_W'(1);
    end
    if (Flush_o && (flushcnt_q != '1)) begin
      flushcnt_d = flushcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      ret_q      <= RUN;
      waitcnt_q  <= '0;
      memerr_q   <= 1'b0;
      stallcnt_q <= '0;
      flushcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      waitcnt_q  <= waitcnt_d;
      memerr_q   <= memerr_d;
      stallcnt_q <= stallcnt_d;
      flushcnt_q <= flushcnt_d;
    end
  end

  assign MemErr_o   = memerr_q;
  assign StallCnt_o = stallcnt_q;
  assign FlushCnt_o = flushcnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random checks of hazard_stall_ctrl
// against a behavioural model, on two parameterisations.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs2u, br, tk, mr, rw, req, ack;

  logic       pcw_a, ifw_a, noop_a, fl_a, fz_a, er_a;
  logic [4:0] sc_a, fc_a;
  logic       pcw_b, ifw_b, noop_b, fl_b, fz_b, er_b;
  logic [31:0] sc_b, fc_b;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS1Addr_i(rs1), .IFID_RS2Addr_i(rs2),
    .IFID_RS2Used_i(rs2u), .IsBranch_i(br),
    .BranchTaken_i(tk), .IDEX_MemRead_i(mr),
    .IDEX_RegWrite_i(rw), .IDEX_RDaddr_i(rd),
    .MemReq_i(req), .MemAck_i(ack),
    .PCWrite_o(pcw_a), .IFIDWrite_o(ifw_a),
    .NoOp_o(noop_a), .Flush_o(fl_a), .Freeze_o(fz_a),
    .MemErr_o(er_a), .StallCnt_o(sc_a), .FlushCnt_o(fc_a)
  );

  hazard_stall_ctrl dut_b (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS1Addr_i(rs1), .IFID_RS2Addr_i(rs2),
    .IFID_RS2Used_i(rs2u), .IsBranch_i(br),
    .BranchTaken_i(tk), .IDEX_MemRead_i(mr),
    .IDEX_RegWrite_i(rw), .IDEX_RDaddr_i(rd),
    .MemReq_i(req), .MemAck_i(ack),
    .PCWrite_o(pcw_b), .IFIDWrite_o(ifw_b),
    .NoOp_o(noop_b), .Flush_o(fl_b), .Freeze_o(fz_b),
    .MemErr_o(er_b), .StallCnt_o(sc_b), .FlushCnt_o(fc_b)
  );

  int errors = 0;
  int checks = 0;

  // model: mode 0 = flowing, 1 = second branch bubble owed, 2 = waiting
  int     mode [2];
  int     retm [2];
  int     wc   [2];
  bit     err  [2];
  longint sc   [2];
  longint fc   [2];
  int     TO   [2] = '{4, 64};
  longint CMAX [2] = '{31, 64'hFFFF_FFFF};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void expect_out(int k, output bit pcw,
      output bit ifw, output bit noop, output bit fl, output bit fz);
    bit hit, mw, stall;
    hit = (rd != 0) && (rd == rs1 || (rs2u && rd == rs2));
    mw = req && !ack;
    stall = (mr && hit) || (br && rw && !mr && hit);
    pcw = 1; ifw = 1; noop = 0; fl = 0; fz = 0;
    if (rst) begin
      pcw = 0; ifw = 0; noop = 1;
    end else if (mode[k] == 2 || mw) begin
      pcw = 0; ifw = 0; fz = 1;
    end else if (mode[k] == 1 || stall) begin
      pcw = 0; ifw = 0; noop = 1;
    end else if (br && tk) begin
      fl = 1;
    end
  endfunction

  task automatic step_model();
    bit pcw, ifw, noop, fl, fz, hit;
    for (int k = 0; k < 2; k++) begin
      expect_out(k, pcw, ifw, noop, fl, fz);
      hit = (rd != 0) && (rd == rs1 || (rs2u && rd == rs2));
      if (rst) begin
        mode[k] = 0; retm[k] = 0; wc[k] = 0;
        err[k] = 0; sc[k] = 0; fc[k] = 0;
      end else begin
        if (!pcw && sc[k] < CMAX[k]) sc[k]++;
        if (fl && fc[k] < CMAX[k]) fc[k]++;
        if (mode[k] == 2) begin
          if (ack || !req) begin
            mode[k] = retm[k]; wc[k] = 0;
          end else if (wc[k] == TO[k]) begin
            err[k] = 1; mode[k] = retm[k]; wc[k] = 0;
          end else begin
            wc[k]++;
          end
        end else if (req && !ack) begin
          retm[k] = mode[k]; mode[k] = 2; wc[k] = 1;
        end else if (mode[k] == 1) begin
          mode[k] = 0;
        end else if (mr && hit && br) begin
          mode[k] = 1;
        end
      end
    end
  endtask

  task automatic compare();
    bit pcw, ifw, noop, fl, fz;
    for (int k = 0; k < 2; k++) begin
      string p;
      p = (k == 0) ? "A" : "B";
      expect_out(k, pcw, ifw, noop, fl, fz);
      chk({p, ".PCWrite"},  k ? pcw_b : pcw_a, pcw);
      chk({p, ".IFIDWrite"}, k ? ifw_b : ifw_a, ifw);
      chk({p, ".NoOp"},     k ? noop_b : noop_a, noop);
      chk({p, ".Flush"},    k ? fl_b : fl_a, fl);
      chk({p, ".Freeze"},   k ? fz_b : fz_a, fz);
      chk({p, ".MemErr"},   k ? er_b : er_a, err[k]);
      chk({p, ".StallCnt"}, k ? 64'(sc_b) : 64'(sc_a), sc[k]);
      chk({p, ".FlushCnt"}, k ? 64'(fc_b) : 64'(fc_a), fc[k]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic tick();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; rs2u = 0; br = 0; tk = 0;
    mr = 0; rw = 0; req = 0; ack = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    sample();
    tick();
    rst = 0;
  endtask

  task automatic ld_br();
    idle();
    mr = 1; rw = 1; rd = 5; rs1 = 5; br = 1; tk = 1;
  endtask

  int nfz;

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; retm[k] = 0; wc[k] = 0;
      err[k] = 0; sc[k] = 0; fc[k] = 0;
    end
    rst = 1;
    idle();
    sample();
    chk("rst.PCWrite", pcw_b, 0);
    chk("rst.NoOp", noop_b, 1);
    chk("rst.Freeze", fz_b, 0);
    tick();
    rst = 0;

    // load-use on ALU op: one bubble
    idle(); mr = 1; rw = 1; rd = 5; rs1 = 5;
    sample();
    chk("lu.PCWrite", pcw_b, 0);
    chk("lu.NoOp", noop_b, 1);
    tick();
    idle(); rs1 = 5;
    sample();
    chk("lu.after", pcw_b, 1);
    chk("lu.StallCnt", sc_b, 1);
    tick();

    // load-to-taken-branch: two bubbles then flush
    do_reset();
    ld_br();
    sample();
    chk("ldbr.c1.PCWrite", pcw_b, 0);
    chk("ldbr.c1.Flush", fl_b, 0);
    tick();
    idle(); rs1 = 5; br = 1; tk = 1;
    sample();
    chk("ldbr.c2.PCWrite", pcw_b, 0);
    chk("ldbr.c2.NoOp", noop_b, 1);
    tick();
    sample();
    chk("ldbr.c3.Flush", fl_b, 1);
    chk("ldbr.c3.PCWrite", pcw_b, 1);
    tick();
    idle();
    sample();
    chk("ldbr.StallCnt", sc_b, 2);
    chk("ldbr.FlushCnt", fc_b, 1);
    tick();

    // ALU result feeding a branch via rs2
    do_reset();
    idle(); rw = 1; rd = 7; rs1 = 2; rs2 = 7; rs2u = 1; br = 1;
    sample();
    chk("alubr.PCWrite", pcw_b, 0);
    chk("alubr.NoOp", noop_b, 1);
    tick();
    idle(); rs1 = 2; rs2 = 7; rs2u = 1; br = 1;
    sample();
    chk("alubr.after", pcw_b, 1);
    tick();

    // x0 destination never stalls
    idle(); mr = 1; rw = 1; rd = 0; rs1 = 0;
    sample();
    chk("x0.PCWrite", pcw_b, 1);
    chk("x0.NoOp", noop_b, 0);
    tick();

    // memory wait with ack on the 6th cycle
    do_reset();
    idle(); req = 1;
    nfz = 0;
    for (int i = 0; i < 6; i++) begin
      ack = (i == 5);
      sample();
      nfz += int'(fz_b);
      tick();
    end
    idle();
    sample();
    chk("mw.FreezeCycles", nfz, 6);
    chk("mw.FreezeAfter", fz_b, 0);
    chk("mw.MemErr", er_b, 0);
    tick();

    // ack in the same cycle as req: no freeze
    idle(); req = 1; ack = 1;
    sample();
    chk("mw.sameack", fz_b, 0);
    tick();

    // timeout on the MEM_TIMEOUT=4 instance
    do_reset();
    idle(); req = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i == 4) chk("to.beforeErr", er_a, 0);
      tick();
    end
    sample();
    chk("to.MemErr", er_a, 1);
    tick();
    idle();
    repeat (3) begin
      sample();
      tick();
    end
    sample();
    chk("to.sticky", er_a, 1);
    tick();
    rst = 1;
    sample();
    tick();
    rst = 0;
    sample();
    chk("to.cleared", er_a, 0);
    tick();

    // reset while owing the second branch bubble
    do_reset();
    ld_br();
    sample();
    tick();
    rst = 1; idle();
    sample();
    chk("rstbr.PCWrite", pcw_b, 0);
    chk("rstbr.NoOp", noop_b, 1);
    tick();
    rst = 0;
    idle(); rs1 = 5; br = 1; tk = 1;
    sample();
    chk("rstbr.noStall", pcw_b, 1);
    chk("rstbr.Flush", fl_b, 1);
    chk("rstbr.StallCnt", sc_b, 0);
    tick();

    // reset while waiting on memory
    do_reset();
    idle(); req = 1;
    sample(); tick();
    sample(); tick();
    rst = 1;
    sample();
    chk("rstmw.Freeze", fz_b, 0);
    tick();
    rst = 0; idle();
    sample();
    chk("rstmw.PCWrite", pcw_b, 1);
    chk("rstmw.Freeze0", fz_b, 0);
    tick();

    // counter saturation on the 5-bit instance
    do_reset();
    idle(); mr = 1; rw = 1; rd = 5; rs1 = 5;
    repeat (40) begin
      sample();
      tick();
    end
    sample();
    chk("sat.A", sc_a, 31);
    chk("sat.B", sc_b, 40);
    tick();

    // random traffic
    do_reset();
    idle();
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(99) == 0);
      rs1  = 5'($urandom_range(3));
      rs2  = 5'($urandom_range(3));
      rd   = 5'($urandom_range(3));
      rs2u = 1'($urandom_range(1));
      br   = 1'($urandom_range(1));
      tk   = 1'($urandom_range(1));
      mr   = 1'($urandom_range(1));
      rw   = 1'($urandom_range(1));
      if (req) req = ($urandom_range(9) != 0);
      else req = ($urandom_range(5) == 0);
      ack  = ($urandom_range(9) < 3);
      sample();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
